pixel_frame_tx: RTL and testbench

- Host-side transmitter that feeds the edge/color chip's pixel loading interface.
- Accepts a 20x20 frame of 5-bit pixels from the host, one pixel per write, into an internal frame buffer.
- On command, streams the frame gap-free as 3 pixels per cycle (pixel_in0..2), raster order, and flags the final beat with load_end.
- The chip has no stall input, so once a burst starts it never pauses.

---
 rtl/pixel_frame_tx.sv | 169 ++++++++++++++++
 tb/tb_pixel_frame_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_tx.sv
// Host-side frame buffer and 3-pixel-per-beat burst transmitter for the edge/color chip.
// Optional build macro TX_CHECKSUM_EN adds an 8-bit running sum (chk_sum) of the pixels in each burst.
module pixel_frame_tx #(
    parameter int IMG_DIM    = 20,
    parameter int BIT_LENGTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [BIT_LENGTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  frame_full,
    input  logic                  start,
    output logic                  busy,
    output logic                  out_valid,
    output logic [BIT_LENGTH-1:0] pixel_in0,
    output logic [BIT_LENGTH-1:0] pixel_in1,
    output logic [BIT_LENGTH-1:0] pixel_in2,
    output logic                  load_end
`ifdef TX_CHECKSUM_EN
    ,
    output logic [7:0]            chk_sum
`endif
);

    localparam int         NPIX      = IMG_DIM * IMG_DIM;
    localparam int         BEATS     = (NPIX + 2) / 3;
    localparam logic [8:0] N_W       = 9'(NPIX);
    localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [8:0]            wptr_q, wptr_d;
    logic [7:0]            bcnt_q, bcnt_d;
    logic                  frame_full_q, frame_full_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  busy_q, busy_d;
    logic                  out_valid_q, out_valid_d;
    logic                  load_end_q, load_end_d;
    logic [BIT_LENGTH-1:0] pix0_q, pix0_d, pix1_q, pix1_d, pix2_q, pix2_d;
    logic [7:0]            chk_q, chk_d;
    logic                  mem_we_s;
    logic [8:0]            addr0_s, addr1_s, addr2_s;
    logic [BIT_LENGTH-1:0] rd0_s, rd1_s, rd2_s;
    logic [BIT_LENGTH-1:0] mem_q [0:NPIX-1];

    // Read addresses of the current beat; padding slots past the frame read as zero.
    always_comb begin
        addr0_s = {1'b0, bcnt_q} * 9'd3;
        addr1_s = addr0_s + 9'd1;
        addr2_s = addr0_s + 9'd2;
        rd0_s   = (addr0_s < N_W) ? mem_q[addr0_s] : '0;
        rd1_s   = (addr1_s < N_W) ? mem_q[addr1_s] : '0;
        rd2_s   = (addr2_s < N_W) ? mem_q[addr2_s] : '0;
    end

    // Next-state logic for the load/send sequencer and all registered outputs.
    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        bcnt_d       = bcnt_q;
        frame_full_d = frame_full_q;
        out_valid_d  = out_valid_q;
        load_end_d   = load_end_q;
        pix0_d       = pix0_q;
        pix1_d       = pix1_q;
        pix2_d       = pix2_q;
        chk_d        = chk_q;
        mem_we_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && frame_full_q) begin
                    state_d = ST_SEND;
                    bcnt_d  = 8'd0;
                    chk_d   = 8'd0;
                end else if (wr_en && wr_ready_q) begin
                    mem_we_s = 1'b1;
                    wptr_d   = wptr_q + 9'd1;
                    if (wptr_q == (N_W - 9'd1)) begin
                        frame_full_d = 1'b1;
                    end else begin
                        frame_full_d = 1'b0;
                    end
                end else begin
                    wptr_d = wptr_q;
                end
            end
            ST_SEND: begin
                if (bcnt_q <= LAST_BEAT) begin
                    out_valid_d = 1'b1;
                    load_end_d  = (bcnt_q == LAST_BEAT);
                    pix0_d      = rd0_s;
                    pix1_d      = rd1_s;
                    pix2_d      = rd2_s;
                    bcnt_d      = bcnt_q + 8'd1;
                    chk_d       = chk_q + 8'(rd0_s) + 8'(rd1_s) + 8'(rd2_s);
                end else begin
                    // Final beat has been shown; the frame is consumed and must be rewritten.
                    state_d      = ST_IDLE;
                    out_valid_d  = 1'b0;
                    load_end_d   = 1'b0;
                    pix0_d       = '0;
                    pix1_d       = '0;
                    pix2_d       = '0;
                    bcnt_d       = 8'd0;
                    wptr_d       = 9'd0;
                    frame_full_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d     = (state_d == ST_SEND);
        wr_ready_d = (state_d == ST_IDLE) && !frame_full_d;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            wptr_q       <= 9'd0;
            bcnt_q       <= 8'd0;
            frame_full_q <= 1'b0;
            wr_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            load_end_q   <= 1'b0;
            pix0_q       <= '0;
            pix1_q       <= '0;
            pix2_q       <= '0;
            chk_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            bcnt_q       <= bcnt_d;
            frame_full_q <= frame_full_d;
            wr_ready_q   <= wr_ready_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            load_end_q   <= load_end_d;
            pix0_q       <= pix0_d;
            pix1_q       <= pix1_d;
            pix2_q       <= pix2_d;
            chk_q        <= chk_d;
        end
    end

    // Frame buffer storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign frame_full = frame_full_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign load_end   = load_end_q;
    assign pixel_in0  = pix0_q;
    assign pixel_in1  = pix1_q;
    assign pixel_in2  = pix2_q;
`ifdef TX_CHECKSUM_EN
    assign chk_sum    = chk_q;
`endif

endmodule

// File: tb/tb_pixel_frame_tx.sv
// Scoreboard bench for pixel_frame_tx: expected beats are queued at start, a negedge monitor checks them.
module tb_pixel_frame_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_data = 5'd0;
    logic       wr_ready, frame_full, busy, out_valid, load_end;
    logic       start = 1'b0;
    logic [4:0] pixel_in0, pixel_in1, pixel_in2;
`ifdef TX_CHECKSUM_EN
    logic [7:0] chk_sum;
`endif

    pixel_frame_tx dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready), .frame_full(frame_full), .start(start), .busy(busy),
        .out_valid(out_valid), .pixel_in0(pixel_in0), .pixel_in1(pixel_in1),
        .pixel_in2(pixel_in2), .load_end(load_end)
`ifdef TX_CHECKSUM_EN
        , .chk_sum(chk_sum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int       idx;
        int       cyc;
        logic [4:0] p0, p1, p2;
        logic     le;
    } beat_t;

    beat_t sb_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    beats_seen = 0;
    int    frame[400];
    int    cap[134][3];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every presented beat must match the head of the scoreboard, including its cycle.
    always @(negedge clk) begin
        beat_t e;
        if (out_valid) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got (%0d,%0d,%0d,le=%0d) at cyc %0d, required no beat",
                         pixel_in0, pixel_in1, pixel_in2, load_end, cyc);
            end else begin
                e = sb_q.pop_front();
                beats_seen++;
                cap[e.idx][0] = pixel_in0;
                cap[e.idx][1] = pixel_in1;
                cap[e.idx][2] = pixel_in2;
                if (pixel_in0 !== e.p0 || pixel_in1 !== e.p1 || pixel_in2 !== e.p2 ||
                    load_end !== e.le || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL beat_%0d: got (%0d,%0d,%0d,le=%0d,cyc=%0d) required (%0d,%0d,%0d,le=%0d,cyc=%0d)",
                             e.idx, pixel_in0, pixel_in1, pixel_in2, load_end, cyc,
                             e.p0, e.p1, e.p2, e.le, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic write_frame(input int mode);
        for (int i = 0; i < 400; i++) begin
            frame[i] = (mode == 0) ? (i % 32) : ((mode == 1) ? ((i * 7 + 3) % 32) : 31);
            wr_en    = 1'b1;
            wr_data  = 5'(frame[i]);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    // Drive a one-cycle start and queue the 134 beats it must produce.
    task automatic issue_start();
        beat_t e;
        beats_seen = 0;
        for (int b = 0; b < 134; b++) begin
            e.idx = b;
            e.cyc = cyc + 2 + b;
            e.p0  = 5'(frame[3 * b]);
            e.p1  = (3 * b + 1 < 400) ? 5'(frame[3 * b + 1]) : 5'd0;
            e.p2  = (3 * b + 2 < 400) ? 5'(frame[3 * b + 2]) : 5'd0;
            e.le  = (b == 133);
            sb_q.push_back(e);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("burst_drained", sb_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_frame_full", frame_full, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_load_end", load_end, 0);
        chk("rst_pixels", {pixel_in0, pixel_in1, pixel_in2}, 0);
        reset = 1'b1;
        @(negedge clk);

        // 399 pixels, then an ignored start; the 400th write coincides with another ignored start.
        for (int i = 0; i < 399; i++) begin
            frame[i] = i % 32;
            wr_en    = 1'b1;
            wr_data  = 5'(frame[i]);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("ff_399", frame_full, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("start_399_busy", busy, 0);
        chk("start_399_wr_ready", wr_ready, 1);
        frame[399] = 399 % 32;
        wr_en   = 1'b1;
        wr_data = 5'(frame[399]);
        start   = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
        chk("ff_400", frame_full, 1);
        chk("wr_ready_full", wr_ready, 0);
        wr_en   = 1'b1;
        wr_data = 5'd7;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("ff_after_401", frame_full, 1);
        chk("simul_start_busy", busy, 0);

        // Burst with repeated start and write pulses during SEND.
        issue_start();
        chk("busy_rise", busy, 1);
        chk("no_beat_yet", out_valid, 0);
        for (int k = 0; k < 20; k++) begin
            start   = 1'b1;
            wr_en   = k[0];
            wr_data = 5'd5;
            @(negedge clk);
        end
        start = 1'b0;
        wr_en = 1'b0;
        wait_drain();
        chk("beats_in_burst", beats_seen, 134);
        chk("post_busy", busy, 0);
        chk("post_out_valid", out_valid, 0);
        chk("post_frame_full", frame_full, 0);
        chk("post_wr_ready", wr_ready, 1);
        chk("post_pixels", {pixel_in0, pixel_in1, pixel_in2}, 0);
        chk("beat0", cap[0][0] * 1024 + cap[0][1] * 32 + cap[0][2], 0 * 1024 + 1 * 32 + 2);
        chk("beat10", cap[10][0] * 1024 + cap[10][1] * 32 + cap[10][2], 30 * 1024 + 31 * 32 + 0);
        chk("beat133", cap[133][0] * 1024 + cap[133][1] * 32 + cap[133][2], 15 * 1024);
        repeat (5) @(negedge clk);
        chk("no_requeue_busy", busy, 0);

        // New frame, then reset while beat 50 is being presented.
        write_frame(1);
        chk("ff_frame2", frame_full, 1);
        issue_start();
        begin
            int n = 0;
            while (beats_seen < 50 && n < 400) begin
                @(posedge clk);
                n++;
            end
        end
        chk("reached_beat50", beats_seen, 50);
        #1 reset = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_load_end", load_end, 0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_wr_ready", wr_ready, 1);
        chk("midrst_frame_full", frame_full, 0);

`ifdef TX_CHECKSUM_EN
        write_frame(2);
        issue_start();
        wait_drain();
        chk("chk_sum_final", chk_sum, 112);
        repeat (6) @(negedge clk);
        chk("chk_sum_held", chk_sum, 112);
`else
        write_frame(2);
        issue_start();
        wait_drain();
        chk("all31_frame_full", frame_full, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
